// File: rtl/block_interleaver_stream_if.sv
// ---------------------------------------------------------------------------
// block_interleaver_stream_if
//
// Groups the serial stream handshakes of the block interleaver.
//
// Signals:
//   in_valid  : producer -> interleaver, in_bit is valid
//   in_ready  : interleaver -> producer, in_bit is accepted this cycle
//   in_bit    : producer -> interleaver, serial data bit
//   mode      : producer -> interleaver, 0 = interleave, 1 = deinterleave
//               (taken on a block's first accepted bit)
//   out_valid : interleaver -> consumer, out_bit is valid
//   out_ready : consumer -> interleaver, out_bit is taken this cycle
//   out_bit   : interleaver -> consumer, serial data bit
//   out_last  : interleaver -> consumer, marks the final bit of a block
//
// Modports:
//   master : the environment side (drives inputs, consumes outputs)
//   slave  : the interleaver side
// ---------------------------------------------------------------------------
interface block_interleaver_stream_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic mode;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_last;

    modport master (
        output in_valid, in_bit, mode, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_bit, mode, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/block_interleaver_stream.sv
// ---------------------------------------------------------------------------
// block_interleaver_stream
//
// Bit-serial block interleaver / deinterleaver with ping-pong buffering.
// A block is S codewords of N bits (L = N*S bits). One bank fills while the
// other drains, so a continuous stream runs at one bit per cycle. The
// interleave/deinterleave choice is captured per block with its first bit.
//
// Parameters:
//   N : codeword length in bits (>= 2)
//   S : codewords per block (>= 2)
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : stream handshakes (slave modport of block_interleaver_stream_if)
// ---------------------------------------------------------------------------
module block_interleaver_stream #(
    parameter int N = 7,
    parameter int S = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    block_interleaver_stream_if.slave     bus
);

    localparam int L  = N * S;
    localparam int AW = $clog2(L);

    localparam logic [AW-1:0] LAST_IDX = AW'(L - 1);
    localparam logic [AW-1:0] N_MAX    = AW'(N - 1);
    localparam logic [AW-1:0] S_MAX    = AW'(S - 1);
    localparam logic [AW-1:0] N_W      = AW'(N);
    localparam logic [AW-1:0] S_W      = AW'(S);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    bank_state_t   state_q [2];
    bank_state_t   state_d [2];
    logic [L-1:0]  mem [2];
    logic          bank_mode [2];

    logic          wb;
    logic          rb;
    logic [AW-1:0] w;
    logic [AW-1:0] outer;
    logic [AW-1:0] inner;

    logic          in_ready;
    logic          accept;
    logic          rd_avail;
    logic          load;
    logic          rd_mode;
    logic          inner_wrap;
    logic          outer_max;
    logic          rd_last;
    logic [AW-1:0] rd_addr;

    logic          out_valid_q;
    logic          out_bit_q;
    logic          out_last_q;

    // Per-bank state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Bank state transitions. The write bank is only ever EMPTY/FILLING and
    // the read bank only FULL/DRAINING, so both updates hit different banks.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (accept) begin
            state_d[wb] = (w == LAST_IDX) ? FULL : FILLING;
        end
        if (load) begin
            state_d[rb] = rd_last ? EMPTY : DRAINING;
        end
    end

    // Handshake decisions and read addressing.
    // The read position is held as two nested counters; the inner counter
    // always multiplies the row pitch, which makes both modes share one
    // address expression with only the pitch and limits swapped:
    //   interleave   : inner = i (0..S-1), outer = j (0..N-1), addr = N*i + j
    //   deinterleave : inner = j (0..N-1), outer = i (0..S-1), addr = S*j + i
    always_comb begin
        in_ready   = (state_q[wb] == EMPTY) || (state_q[wb] == FILLING);
        accept     = bus.in_valid & in_ready;
        rd_avail   = (state_q[rb] == FULL) || (state_q[rb] == DRAINING);
        load       = rd_avail & (~out_valid_q | bus.out_ready);
        rd_mode    = bank_mode[rb];
        inner_wrap = rd_mode ? (inner == N_MAX) : (inner == S_MAX);
        outer_max  = rd_mode ? (outer == S_MAX) : (outer == N_MAX);
        rd_last    = inner_wrap & outer_max;
        rd_addr    = rd_mode ? (S_W * inner + outer) : (N_W * inner + outer);
    end

    // Write pointer, write index and per-bank mode capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb           <= 1'b0;
            w            <= '0;
            bank_mode[0] <= 1'b0;
            bank_mode[1] <= 1'b0;
        end else if (accept) begin
            if (w == '0) begin
                bank_mode[wb] <= bus.mode;
            end
            if (w == LAST_IDX) begin
                w  <= '0;
                wb <= ~wb;
            end else begin
                w <= w + 1'b1;
            end
        end
    end

    // Bank storage; contents need no reset because bank state gates reads.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wb][w] <= bus.in_bit;
        end
    end

    // Output register and read counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb          <= 1'b0;
            outer       <= '0;
            inner       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= mem[rb][rd_addr];
            out_last_q  <= rd_last;
            if (inner_wrap) begin
                inner <= '0;
                if (rd_last) begin
                    outer <= '0;
                    rb    <= ~rb;
                end else begin
                    outer <= outer + 1'b1;
                end
            end else begin
                inner <= inner + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_block_interleaver_stream.sv
// ---------------------------------------------------------------------------
// tb_block_interleaver_stream
//
// Self-checking bench for block_interleaver_stream (N=7, S=4). Blocks are
// queued as input bits plus the mode presented with each bit; the expected
// output of block b at position p is computed directly from the column/row
// reordering rule using the mode seen on the block's first bit.
// ---------------------------------------------------------------------------
module tb_block_interleaver_stream;

    localparam int N = 7;
    localparam int S = 4;
    localparam int L = N * S;

    logic clk = 1'b0;
    logic rst = 1'b1;

    block_interleaver_stream_if bus ();

    block_interleaver_stream #(.N(N), .S(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;

    logic in_q[$];
    logic mode_q[$];
    logic got_bit[$];
    logic got_last[$];
    int   got_cyc[$];
    int   acc_cyc[$];
    int   acc_idx;
    int   ready_low;
    bit   timed_out;

    // Expected output bit of block b at output position p.
    function automatic logic model_bit(input int b, input int p);
        int a;
        if (mode_q[b * L] == 1'b0) a = N * (p % S) + p / S;
        else                       a = S * (p % N) + p / N;
        return in_q[b * L + a];
    endfunction

    task automatic clear_scoreboard();
        in_q.delete();
        mode_q.delete();
        got_bit.delete();
        got_last.delete();
        got_cyc.delete();
        acc_cyc.delete();
        acc_idx = 0;
    endtask

    task automatic add_block(input logic [L-1:0] bits, input logic m);
        for (int k = 0; k < L; k++) begin
            in_q.push_back(bits[k]);
            mode_q.push_back(m);
        end
    endtask

    // Drives queued input bits and collects output bits, with random
    // in_valid / out_ready duty cycles (percent), for at most max_cycles.
    task automatic stream(input int pin, input int pout, input int max_cycles);
        int   total;
        int   cyc;
        logic iv;
        total     = in_q.size();
        cyc       = 0;
        ready_low = 0;
        timed_out = 1'b0;
        while ((acc_idx < total || got_bit.size() < total) && cyc < max_cycles) begin
            @(negedge clk);
            iv = (acc_idx < total) && ($urandom_range(99) < pin);
            bus.in_valid  = iv;
            bus.in_bit    = iv ? in_q[acc_idx]   : 1'($urandom);
            bus.mode      = iv ? mode_q[acc_idx] : 1'($urandom);
            bus.out_ready = ($urandom_range(99) < pout);
            #1;
            if (iv && !bus.in_ready) ready_low++;
            if (iv && bus.in_ready) begin
                acc_cyc.push_back(cyc);
                acc_idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got_bit.push_back(bus.out_bit);
                got_last.push_back(bus.out_last);
                got_cyc.push_back(cyc);
            end
            cyc++;
        end
        if (acc_idx < total || got_bit.size() < total) timed_out = 1'b1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = ordy;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_last: got %0b expected 0", bus.out_last);
        end
        checks++;
        if (bus.out_bit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_bit: got %0b expected 0", bus.out_bit);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_interleave_single();
        logic [L-1:0] one;
        int           exp_pos [3];
        int           ones;
        int           pos;
        one        = 1;
        exp_pos[0] = 1;
        exp_pos[1] = 3;
        exp_pos[2] = 4;
        clear_scoreboard();
        add_block(one << 7, 1'b0);
        add_block(one << 21, 1'b0);
        add_block(one << 1, 1'b0);
        stream(70, 70, 3000);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != 3 * L) begin
            failures++;
            $display("[TB] FAIL ilv_single_count: got %0d bits expected %0d", got_bit.size(), 3 * L);
        end else begin
            for (int b = 0; b < 3; b++) begin
                ones = 0;
                pos  = -1;
                for (int p = 0; p < L; p++) begin
                    if (got_bit[b * L + p] === 1'b1) begin
                        ones++;
                        pos = p;
                    end
                end
                checks++;
                if (ones != 1 || pos != exp_pos[b]) begin
                    failures++;
                    $display("[TB] FAIL ilv_single_pos block %0d: got pos %0d (ones %0d) expected pos %0d", b, pos, ones, exp_pos[b]);
                end
            end
            for (int k = 0; k < 3 * L; k++) begin
                checks++;
                if (got_last[k] !== ((k % L) == L - 1)) begin
                    failures++;
                    $display("[TB] FAIL ilv_single_last bit %0d: got %0b expected %0b", k, got_last[k], (k % L) == L - 1);
                end
            end
        end
    endtask

    task automatic test_deinterleave();
        logic [L-1:0] one;
        logic [L-1:0] pattern;
        logic [L-1:0] v;
        int           ones;
        int           pos;
        one     = 1;
        pattern = 28'h0A5F3C1;
        clear_scoreboard();
        add_block(one << 1, 1'b1);
        stream(70, 70, 2000);
        ones = 0;
        pos  = -1;
        for (int p = 0; p < got_bit.size(); p++) begin
            if (got_bit[p] === 1'b1) begin
                ones++;
                pos = p;
            end
        end
        checks++;
        if (timed_out !== 1'b0 || ones != 1 || pos != 7) begin
            failures++;
            $display("[TB] FAIL dil_single_pos: got pos %0d (ones %0d) expected pos 7", pos, ones);
        end

        clear_scoreboard();
        add_block(pattern, 1'b0);
        stream(80, 80, 2000);
        v = '0;
        for (int k = 0; k < L && k < got_bit.size(); k++) v[k] = got_bit[k];
        clear_scoreboard();
        add_block(v, 1'b1);
        stream(80, 80, 2000);
        v = '0;
        for (int k = 0; k < L && k < got_bit.size(); k++) v[k] = got_bit[k];
        checks++;
        if (timed_out !== 1'b0 || v !== pattern) begin
            failures++;
            $display("[TB] FAIL round_trip: got %h expected %h", v, pattern);
        end
    endtask

    task automatic test_back_to_back();
        int gaps;
        clear_scoreboard();
        for (int b = 0; b < 3; b++) add_block(L'({$urandom, $urandom}), 1'($urandom));
        stream(100, 100, 400);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != 3 * L) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d bits expected %0d", got_bit.size(), 3 * L);
        end else begin
            checks++;
            if (ready_low != 0) begin
                failures++;
                $display("[TB] FAIL b2b_in_ready: got %0d stalled cycles expected 0", ready_low);
            end
            checks++;
            if (got_cyc[0] != acc_cyc[L - 1] + 2 || got_cyc[0] != 29) begin
                failures++;
                $display("[TB] FAIL b2b_latency: got first out at cycle %0d expected 29", got_cyc[0]);
            end
            gaps = 0;
            for (int k = 1; k < 3 * L; k++) if (got_cyc[k] != got_cyc[0] + k) gaps++;
            checks++;
            if (gaps != 0) begin
                failures++;
                $display("[TB] FAIL b2b_contiguous: got %0d gaps expected 0", gaps);
            end
            for (int k = 0; k < 3 * L; k++) begin
                checks++;
                if (got_bit[k] !== model_bit(k / L, k % L)) begin
                    failures++;
                    $display("[TB] FAIL b2b_data bit %0d: got %0b expected %0b", k, got_bit[k], model_bit(k / L, k % L));
                end
                checks++;
                if (got_last[k] !== (k == 27 || k == 55 || k == 83)) begin
                    failures++;
                    $display("[TB] FAIL b2b_last bit %0d: got %0b expected %0b", k, got_last[k], (k == 27 || k == 55 || k == 83));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic exp0;
        clear_scoreboard();
        for (int b = 0; b < 3; b++) add_block(L'({$urandom, $urandom}), 1'($urandom));
        exp0 = model_bit(0, 0);
        stream(100, 0, 70);
        checks++;
        if (acc_idx != 2 * L) begin
            failures++;
            $display("[TB] FAIL bp_accepted: got %0d expected %0d", acc_idx, 2 * L);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_in_ready: got %0b expected 0", bus.in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            idle(1, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== exp0 || bus.out_last !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold cycle %0d: got v=%0b b=%0b l=%0b expected v=1 b=%0b l=0", k, bus.out_valid, bus.out_bit, bus.out_last, exp0);
            end
        end
        stream(100, 100, 500);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != 3 * L) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d bits expected %0d", got_bit.size(), 3 * L);
        end else begin
            for (int k = 0; k < 3 * L; k++) begin
                checks++;
                if (got_bit[k] !== model_bit(k / L, k % L)) begin
                    failures++;
                    $display("[TB] FAIL bp_data bit %0d: got %0b expected %0b", k, got_bit[k], model_bit(k / L, k % L));
                end
            end
        end
    endtask

    task automatic test_mode_toggle();
        logic         m0;
        logic [L-1:0] b1;
        logic [L-1:0] b2;
        m0 = 1'($urandom);
        b1 = L'({$urandom, $urandom});
        b2 = L'({$urandom, $urandom});
        clear_scoreboard();
        for (int k = 0; k < L; k++) begin
            in_q.push_back(b1[k]);
            mode_q.push_back(k < 10 ? m0 : ~m0);
        end
        add_block(b2, ~m0);
        stream(80, 80, 2000);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != 2 * L) begin
            failures++;
            $display("[TB] FAIL mode_count: got %0d bits expected %0d", got_bit.size(), 2 * L);
        end else begin
            for (int k = 0; k < 2 * L; k++) begin
                checks++;
                if (got_bit[k] !== model_bit(k / L, k % L)) begin
                    failures++;
                    $display("[TB] FAIL mode_data bit %0d: got %0b expected %0b", k, got_bit[k], model_bit(k / L, k % L));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_scoreboard();
        add_block(L'({$urandom, $urandom}), 1'($urandom));
        add_block(L'({$urandom, $urandom}), 1'($urandom));
        stream(100, 100, L + 15);
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset: got out_valid=%0b in_ready=%0b expected 0 and 1", bus.out_valid, bus.in_ready);
        end
        clear_scoreboard();
        add_block(L'({$urandom, $urandom}), 1'($urandom));
        stream(70, 70, 2000);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != L) begin
            failures++;
            $display("[TB] FAIL mid_fresh_count: got %0d bits expected %0d", got_bit.size(), L);
        end else begin
            for (int k = 0; k < L; k++) begin
                checks++;
                if (got_bit[k] !== model_bit(0, k)) begin
                    failures++;
                    $display("[TB] FAIL mid_fresh_data bit %0d: got %0b expected %0b", k, got_bit[k], model_bit(0, k));
                end
            end
        end
        idle(6, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_residue: got out_valid=%0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        clear_scoreboard();
        for (int b = 0; b < 4; b++) add_block(L'({$urandom, $urandom}), 1'($urandom));
        stream(50, 50, 4000);
        checks++;
        if (timed_out !== 1'b0 || got_bit.size() != 4 * L) begin
            failures++;
            $display("[TB] FAIL rand_count: got %0d bits expected %0d", got_bit.size(), 4 * L);
        end else begin
            for (int k = 0; k < 4 * L; k++) begin
                checks++;
                if (got_bit[k] !== model_bit(k / L, k % L)) begin
                    failures++;
                    $display("[TB] FAIL rand_data bit %0d: got %0b expected %0b", k, got_bit[k], model_bit(k / L, k % L));
                end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        $display("[TB] starting block_interleaver_stream bench");
        test_reset();
        test_interleave_single();
        test_deinterleave();
        test_back_to_back();
        test_backpressure();
        test_mode_toggle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
